// File: rtl/cheshire_boot_seq.sv
// Regbus boot sequencer: waits for LLC BIST, configures the LLC as SPM, loads the entry point,
// wakes the core, then polls the EOC scratch register and reports the exit status.
module cheshire_boot_seq #(
  parameter int unsigned          AddrWidth    = 48,
  parameter logic [AddrWidth-1:0] LlcCfgAddr   = 48'h0300_1000,
  parameter logic [31:0]          LlcSpmVal    = 32'hFFFF_FFFF,
  parameter logic [AddrWidth-1:0] EntryLoAddr  = 48'h0300_0000,
  parameter logic [AddrWidth-1:0] EntryHiAddr  = 48'h0300_0004,
  parameter logic [AddrWidth-1:0] WakeAddr     = 48'h0300_0008,
  parameter logic [AddrWidth-1:0] EocAddr      = 48'h0300_000C,
  parameter int unsigned          PollInterval = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [63:0]          entry_i,
  input  logic                 bist_done_i,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic [AddrWidth-1:0] req_addr_o,
  output logic                 req_write_o,
  output logic [31:0]          req_wdata_o,
  input  logic                 rsp_valid_i,
  input  logic [31:0]          rsp_rdata_i,
  input  logic                 rsp_error_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [30:0]          exit_status_o
);

  typedef enum logic [3:0] {
    StIdle, StBist, StCfgLlc, StWrLo, StWrHi, StWake, StPollWait, StPollRd, StDone, StError
  } state_e;

  typedef enum logic [1:0] {PhIssue, PhReq, PhRsp} phase_e;

  state_e                 state_q, state_d;
  phase_e                 phase_q, phase_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [63:0]            entry_q, entry_d;
  logic                   req_valid_q, req_valid_d;
  logic [AddrWidth-1:0]   req_addr_q, req_addr_d;
  logic                   req_write_q, req_write_d;
  logic [31:0]            req_wdata_q, req_wdata_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [30:0]            exit_q, exit_d;

  // Per-state transaction description and successor state.
  logic [AddrWidth-1:0]   bus_addr;
  logic                   bus_write;
  logic [31:0]            bus_wdata;
  state_e                 bus_next;

  always_comb begin
    bus_addr  = '0;
    bus_write = 1'b0;
    bus_wdata = '0;
    bus_next  = StIdle;
    unique case (state_q)
      StCfgLlc: begin bus_addr = LlcCfgAddr;  bus_write = 1'b1; bus_wdata = LlcSpmVal;
                      bus_next = StWrLo; end
      StWrLo:   begin bus_addr = EntryLoAddr; bus_write = 1'b1; bus_wdata = entry_q[31:0];
                      bus_next = StWrHi; end
      StWrHi:   begin bus_addr = EntryHiAddr; bus_write = 1'b1; bus_wdata = entry_q[63:32];
                      bus_next = StWake; end
      StWake:   begin bus_addr = WakeAddr;    bus_write = 1'b1; bus_wdata = 32'h1;
                      bus_next = StPollWait; end
      StPollRd: begin bus_addr = EocAddr;     bus_next = StPollWait; end
      default:  ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    entry_d     = entry_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_write_d = req_write_q;
    req_wdata_d = req_wdata_q;
    done_d      = done_q;
    err_d       = err_q;
    exit_d      = exit_q;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start_i) begin
          entry_d = entry_i;
          done_d  = 1'b0;
          err_d   = 1'b0;
          exit_d  = '0;
          state_d = StBist;
        end
      end
      StBist: begin
        if (bist_done_i) begin
          state_d = StCfgLlc;
          phase_d = PhIssue;
        end
      end
      StPollWait: begin
        cnt_d = cnt_q - 32'd1;
        // Raise the EOC read on the last wait cycle so the idle gap is exactly PollInterval.
        if (cnt_q == 32'd1) begin
          state_d     = StPollRd;
          phase_d     = PhReq;
          req_valid_d = 1'b1;
          req_addr_d  = EocAddr;
          req_write_d = 1'b0;
          req_wdata_d = '0;
        end
      end
      default: begin
        unique case (phase_q)
          PhIssue: begin
            req_valid_d = 1'b1;
            req_addr_d  = bus_addr;
            req_write_d = bus_write;
            req_wdata_d = bus_wdata;
            phase_d     = PhReq;
          end
          PhReq: begin
            if (req_ready_i) begin
              req_valid_d = 1'b0;
              phase_d     = PhRsp;
            end
          end
          default: begin
            if (rsp_valid_i) begin
              phase_d = PhIssue;
              if (rsp_error_i) begin
                err_d   = 1'b1;
                state_d = StError;
              end else if (state_q == StPollRd && rsp_rdata_i[0]) begin
                exit_d  = rsp_rdata_i[31:1];
                done_d  = 1'b1;
                state_d = StDone;
              end else begin
                state_d = bus_next;
                cnt_d   = PollInterval;
              end
            end
          end
        endcase
      end
    endcase

    busy_d = !(state_d inside {StIdle, StDone, StError});
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      phase_q     <= PhIssue;
      cnt_q       <= '0;
      entry_q     <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_write_q <= 1'b0;
      req_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      exit_q      <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      entry_q     <= entry_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_write_q <= req_write_d;
      req_wdata_q <= req_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      exit_q      <= exit_d;
    end
  end

  assign req_valid_o   = req_valid_q;
  assign req_addr_o    = req_addr_q;
  assign req_write_o   = req_write_q;
  assign req_wdata_o   = req_wdata_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign exit_status_o = exit_q;

endmodule
